// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: update sequencer for the branch predictor (BHT + BTB).
// Buffers resolved branches in a small FIFO and drains them into the
// predictor's single write port, sweeps both tables clear after reset and
// raises a one-cycle pipeline flush after every accepted misprediction.
// Optional feature macro: BP_UPDATE_STATS_EN (branch/misprediction counters).
module bp_update_ctrl #(
  parameter int IDX_W = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [15:0]      res_pc,
  input  logic             res_taken,
  input  logic [15:0]      res_target,
  input  logic             res_mispredicted,
  output logic             upd_en,
  input  logic             upd_ready,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic [15:0]      upd_target,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_idx,
  output logic             busy,
  output logic             flush,
  output logic [15:0]      br_cnt,
  output logic [15:0]      mis_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = IDX_W + 1 + 16;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             flush_q, flush_d;

  logic full, empty, enq, deq;
  logic [ENT_W-1:0] head;

  // PC bits outside the table index are intentionally not stored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{res_pc[15:IDX_W+1], res_pc[0]};

  // State register for the clear sweep / run sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next state: step the sweep one index per cycle, leave after the last one.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy      = 1'b0;
    clr_en    = 1'b0;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        clr_en    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == {IDX_W{1'b1}}) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy   = 1'b0;
        clr_en = 1'b0;
      end
      default: begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  assign clr_idx = clr_idx_q;

  // FIFO status and handshakes; a full FIFO never bypasses on a dequeue.
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign res_ready = (state_q == RUN) && !full;
  assign upd_en    = (state_q == RUN) && !empty;
  assign enq       = res_valid && res_ready;
  assign deq       = upd_en && upd_ready;

  // Pointer, occupancy and flush next-state logic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flush_d  = enq && res_mispredicted;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers and the registered flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flush_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flush_q  <= flush_d;
    end
  end

  // Entry storage: index, outcome and target of each accepted branch.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= {res_pc[IDX_W:1], res_taken, res_target};
    end
  end

  // The head entry is presented directly so a fresh entry is visible next cycle.
  assign head       = mem_q[rd_ptr_q];
  assign upd_idx    = head[ENT_W-1 -: IDX_W];
  assign upd_taken  = head[16];
  assign upd_target = head[15:0];
  assign flush      = flush_q;

`ifdef BP_UPDATE_STATS_EN
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] mis_cnt_q, mis_cnt_d;

  // Saturating counters of accepted branches and accepted mispredictions.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (enq && (br_cnt_q != 16'hFFFF)) begin
      br_cnt_d = br_cnt_q + 16'd1;
    end
    if (enq && res_mispredicted && (mis_cnt_q != 16'hFFFF)) begin
      mis_cnt_d = mis_cnt_q + 16'd1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`else
  assign br_cnt  = 16'd0;
  assign mis_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl (IDX_W=3, DEPTH=4): directed
// scenarios plus randomized traffic compared against a queue-based model.
module tb_bp_update_ctrl;

  localparam int IDX_W = 3;
  localparam int DEPTH = 4;
  localparam int NIDX  = 1 << IDX_W;
`ifdef BP_UPDATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_pc;
  logic        res_taken;
  logic [15:0] res_target;
  logic        res_mispredicted;
  logic        upd_en;
  logic        upd_ready;
  logic [IDX_W-1:0] upd_idx;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        clr_en;
  logic [IDX_W-1:0] clr_idx;
  logic        busy;
  logic        flush;
  logic [15:0] br_cnt;
  logic [15:0] mis_cnt;

  bp_update_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target),
    .res_mispredicted(res_mispredicted),
    .upd_en(upd_en), .upd_ready(upd_ready), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .clr_en(clr_en), .clr_idx(clr_idx), .busy(busy), .flush(flush),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: pending updates as a queue, sweep progress, flush, counters.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic [15:0]      target;
  } ent_t;

  ent_t        mq[$];
  int          m_sweep = 0;
  bit          m_flush = 1'b0;
  logic [15:0] m_br = 16'd0;
  logic [15:0] m_mis = 16'd0;

  function automatic bit m_ready();
    return (m_sweep >= NIDX) && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_upd();
    return (m_sweep >= NIDX) && (mq.size() > 0);
  endfunction

  // Advance one clock: update the model from the applied inputs, settle at negedge.
  task automatic tick();
    bit   acc, deq;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_flush = 1'b0;
      m_br    = 16'd0;
      m_mis   = 16'd0;
      m_sweep = 0;
    end else begin
      acc = res_valid && m_ready();
      deq = m_upd() && upd_ready;
      if (deq) void'(mq.pop_front());
      if (acc) begin
        e.idx    = res_pc[IDX_W:1];
        e.taken  = res_taken;
        e.target = res_target;
        mq.push_back(e);
      end
      m_flush = acc && res_mispredicted;
      if (acc && m_br != 16'hFFFF) m_br = m_br + 16'd1;
      if (acc && res_mispredicted && m_mis != 16'hFFFF) m_mis = m_mis + 16'd1;
      if (m_sweep < NIDX) m_sweep++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
    res_target = '0; res_mispredicted = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_inputs(); tick();
    rst = 1'b0;
    repeat (NIDX) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); upd_ready = 1'b0;
    tick();
    checks++;
    if ({busy, clr_en, clr_idx, upd_en, res_ready, flush} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL reset_outputs busy=%b clr_en=%b clr_idx=%0d upd_en=%b res_ready=%b flush=%b want 1 1 0 0 0 0", busy, clr_en, clr_idx, upd_en, res_ready, flush); end
    checks++;
    if ({br_cnt, mis_cnt} !== 32'd0)
      begin errors++; $display("FAIL reset_counters br=%0d mis=%0d want 0 0", br_cnt, mis_cnt); end
    rst = 1'b0;
    for (int i = 0; i < NIDX; i++) begin
      checks++;
      if (clr_idx !== 3'(i) || clr_en !== 1'b1 || busy !== 1'b1 || res_ready !== 1'b0)
        begin errors++; $display("FAIL sweep_step%0d clr_idx=%0d clr_en=%b busy=%b res_ready=%b want %0d 1 1 0", i, clr_idx, clr_en, busy, res_ready, i); end
      tick();
    end
    checks++;
    if (res_ready !== 1'b1 || busy !== 1'b0 || clr_en !== 1'b0)
      begin errors++; $display("FAIL sweep_done res_ready=%b busy=%b clr_en=%b want 1 0 0", res_ready, busy, clr_en); end
  endtask

  task automatic test_single_mispredict();
    res_valid = 1'b1; res_pc = 16'h0008; res_taken = 1'b1;
    res_target = 16'h0080; res_mispredicted = 1'b1; upd_ready = 1'b1;
    checks++;
    if (res_ready !== 1'b1)
      begin errors++; $display("FAIL mis_ready res_ready=%b want 1", res_ready); end
    tick();
    idle_inputs();
    checks++;
    if ({upd_en, upd_idx, upd_taken, upd_target, flush} !== {1'b1, 3'h4, 1'b1, 16'h0080, 1'b1})
      begin errors++; $display("FAIL mis_update upd_en=%b idx=%h taken=%b target=%h flush=%b want 1 4 1 0080 1", upd_en, upd_idx, upd_taken, upd_target, flush); end
    tick();
    checks++;
    if (upd_en !== 1'b0 || flush !== 1'b0)
      begin errors++; $display("FAIL mis_after upd_en=%b flush=%b want 0 0", upd_en, flush); end
  endtask

  task automatic test_backpressure();
    logic [IDX_W-1:0] s_idx [4];
    logic [15:0]      s_tgt [4];
    int               n_acc = 0;
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1; res_pc = 16'($urandom); res_taken = 1'($urandom);
      res_target = 16'($urandom); res_mispredicted = 1'b0;
      if (res_ready === 1'b1 && n_acc < 4) begin
        s_idx[n_acc] = res_pc[IDX_W:1]; s_tgt[n_acc] = res_target; n_acc++;
      end
      if (i == 4) begin
        checks++;
        if (res_ready !== 1'b0)
          begin errors++; $display("FAIL full_ready res_ready=%b want 0", res_ready); end
      end
      if (i >= 2) begin
        checks++;
        if (upd_en !== 1'b1 || upd_idx !== s_idx[0] || upd_target !== s_tgt[0])
          begin errors++; $display("FAIL stall_hold upd_en=%b idx=%h target=%h want 1 %h %h", upd_en, upd_idx, upd_target, s_idx[0], s_tgt[0]); end
      end
      tick();
    end
    checks++;
    if (n_acc != 4)
      begin errors++; $display("FAIL full_accepts got=%0d want 4", n_acc); end
    idle_inputs(); upd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (upd_en !== 1'b1 || upd_idx !== s_idx[k] || upd_target !== s_tgt[k])
        begin errors++; $display("FAIL drain%0d upd_en=%b idx=%h target=%h want 1 %h %h", k, upd_en, upd_idx, upd_target, s_idx[k], s_tgt[k]); end
      if (k < 2) begin
        checks++;
        if (res_ready !== 1'(k))
          begin errors++; $display("FAIL drain_ready%0d res_ready=%b want %0d", k, res_ready, k); end
      end
      tick();
    end
    checks++;
    if (upd_en !== 1'b0)
      begin errors++; $display("FAIL drain_empty upd_en=%b want 0", upd_en); end
  endtask

  task automatic test_back_to_back();
    logic [IDX_W-1:0] eq_idx[$];
    logic [15:0]      eq_tgt[$];
    upd_ready = 1'b0;
    // Preload two entries, then stream eight more with a dequeue every cycle.
    for (int i = 0; i < 10; i++) begin
      res_valid = 1'b1; res_pc = 16'($urandom); res_taken = 1'($urandom);
      res_target = 16'($urandom); res_mispredicted = 1'b1;
      if (i == 2) upd_ready = 1'b1;
      if (i >= 2) begin
        checks++;
        if (res_ready !== 1'b1 || upd_en !== 1'b1 || upd_idx !== eq_idx[0] || upd_target !== eq_tgt[0])
          begin errors++; $display("FAIL b2b_head%0d ready=%b upd_en=%b idx=%h target=%h want 1 1 %h %h", i, res_ready, upd_en, upd_idx, upd_target, eq_idx[0], eq_tgt[0]); end
        void'(eq_idx.pop_front()); void'(eq_tgt.pop_front());
      end
      if (i >= 1) begin
        checks++;
        if (flush !== 1'b1)
          begin errors++; $display("FAIL b2b_flush%0d flush=%b want 1", i, flush); end
      end
      eq_idx.push_back(res_pc[IDX_W:1]); eq_tgt.push_back(res_target);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (upd_en !== 1'b1 || upd_idx !== eq_idx[0] || upd_target !== eq_tgt[0])
        begin errors++; $display("FAIL b2b_tail%0d upd_en=%b idx=%h target=%h want 1 %h %h", k, upd_en, upd_idx, upd_target, eq_idx[0], eq_tgt[0]); end
      void'(eq_idx.pop_front()); void'(eq_tgt.pop_front());
      tick();
    end
    checks++;
    if (upd_en !== 1'b0 || flush !== 1'b0)
      begin errors++; $display("FAIL b2b_end upd_en=%b flush=%b want 0 0", upd_en, flush); end
  endtask

  task automatic test_reset_mid();
    upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_pc = 16'($urandom); res_taken = 1'b1;
      res_target = 16'($urandom); res_mispredicted = (i == 2);
      tick();
    end
    idle_inputs();
    checks++;
    if (upd_en !== 1'b1 || flush !== 1'b1)
      begin errors++; $display("FAIL midrst_pre upd_en=%b flush=%b want 1 1", upd_en, flush); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({upd_en, flush, clr_idx, busy, clr_en, res_ready} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0})
      begin errors++; $display("FAIL midrst_post upd_en=%b flush=%b clr_idx=%0d busy=%b clr_en=%b ready=%b want 0 0 0 1 1 0", upd_en, flush, clr_idx, busy, clr_en, res_ready); end
    repeat (NIDX) tick();
    checks++;
    if (res_ready !== 1'b1 || upd_en !== 1'b0)
      begin errors++; $display("FAIL midrst_run res_ready=%b upd_en=%b want 1 0", res_ready, upd_en); end
  endtask

  task automatic test_stats();
    do_reset();
    upd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      res_valid = 1'b1; res_pc = 16'($urandom); res_taken = 1'($urandom);
      res_target = 16'($urandom); res_mispredicted = (i == 1 || i == 4);
      tick();
    end
    idle_inputs();
    checks++;
    if (br_cnt !== (STATS ? 16'd6 : 16'd0) || mis_cnt !== (STATS ? 16'd2 : 16'd0))
      begin errors++; $display("FAIL stats br=%0d mis=%0d want %0d %0d", br_cnt, mis_cnt, STATS ? 6 : 0, STATS ? 2 : 0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(149) == 0);
      res_valid = ($urandom_range(3) != 0);
      res_pc = 16'($urandom); res_taken = 1'($urandom);
      res_target = 16'($urandom); res_mispredicted = ($urandom_range(2) == 0);
      upd_ready = ($urandom_range(9) < 6);
      tick();
      checks++;
      if (busy !== (m_sweep < NIDX) || clr_en !== (m_sweep < NIDX) ||
          (m_sweep < NIDX && clr_idx !== 3'(m_sweep)))
        begin errors++; $display("FAIL rnd_sweep c=%0d busy=%b clr_en=%b clr_idx=%0d want busy %b idx %0d", c, busy, clr_en, clr_idx, m_sweep < NIDX, m_sweep); end
      checks++;
      if (res_ready !== m_ready() || upd_en !== m_upd())
        begin errors++; $display("FAIL rnd_hs c=%0d res_ready=%b upd_en=%b want %b %b", c, res_ready, upd_en, m_ready(), m_upd()); end
      if (m_upd()) begin
        checks++;
        if ({upd_idx, upd_taken, upd_target} !== mq[0])
          begin errors++; $display("FAIL rnd_head c=%0d idx=%h taken=%b target=%h want %h %b %h", c, upd_idx, upd_taken, upd_target, mq[0].idx, mq[0].taken, mq[0].target); end
      end
      checks++;
      if (flush !== m_flush)
        begin errors++; $display("FAIL rnd_flush c=%0d flush=%b want %b", c, flush, m_flush); end
      checks++;
      if (br_cnt !== (STATS ? m_br : 16'd0) || mis_cnt !== (STATS ? m_mis : 16'd0))
        begin errors++; $display("FAIL rnd_cnt c=%0d br=%0d mis=%0d want %0d %0d", c, br_cnt, mis_cnt, STATS ? m_br : 16'd0, STATS ? m_mis : 16'd0); end
    end
  endtask

  initial begin
    rst = 1'b1; upd_ready = 1'b0; idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_mispredict();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Update sequencer for the dynamic branch predictor (BHT + BTB). It sits between the decode-stage branch resolution logic and the predictor's single write port. It buffers resolved branch outcomes in a small FIFO and drains them into the predictor one per accepted handshake. It also sweeps both tables clear after reset and issues a registered pipeline-flush pulse on every accepted misprediction.

## Interface
Parameters:
- IDX_W, 3, predictor index width (index = PC[IDX_W:1])
- DEPTH, 4, update FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- res_valid  in  1  decode stage presents a resolved branch
- res_ready  out  1  controller can accept a resolution this cycle
- res_pc  in  16  PC of the resolved branch
- res_taken  in  1  actual branch outcome
- res_target  in  16  actual branch target
- res_mispredicted  in  1  decode detected a misprediction
- upd_en  out  1  write request to the predictor
- upd_ready  in  1  predictor accepts the write this cycle
- upd_idx  out  IDX_W  table index, equal to res_pc[IDX_W:1]
- upd_taken  out  1  outcome to train the BHT counter
- upd_target  out  16  BTB target; written only when upd_taken=1
- clr_en  out  1  clear-sweep write strobe
- clr_idx  out  IDX_W  index being cleared
- busy  out  1  clear sweep in progress
- flush  out  1  one-cycle IF/ID flush pulse
- br_cnt  out  16  accepted-branch counter (see Configuration)
- mis_cnt  out  16  accepted-misprediction counter (see Configuration)

## Operation
State machine: CLEAR and RUN.

CLEAR:
- Entered on rst.
- clr_en=1 and clr_idx counts 0..2^IDX_W−1, one index per cycle. The predictor write is unconditional; upd_ready is ignored.
- After the last index is cleared, transition to RUN.
- busy=1 and res_ready=0 throughout.

RUN:
- busy=0 and clr_en=0.
- res_ready = !full.
- Accept (enqueue) = res_valid && res_ready. The entry stores idx, taken, target.
- The head entry drives upd_idx, upd_taken and upd_target. upd_en = !empty.
- Dequeue = upd_en && upd_ready.
- Enqueue and dequeue in the same cycle are both performed and the count is unchanged. When full, res_ready=0 even if a dequeue occurs that cycle (no bypass).
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits; full means count==DEPTH, empty means count==0.

Flush:
- flush=1 in the cycle after an accept with res_mispredicted=1; 0 otherwise.
- res_mispredicted is ignored when res_valid=0 or res_ready=0.

Reset mid-operation:
- FIFO is emptied, pending flush is dropped, counters are zeroed.
- The sweep restarts at index 0 regardless of the current state.

## Timing
- Reset values, registered on the first posedge with rst=1: busy=1, clr_en=1, clr_idx=0, upd_en=0, res_ready=0, flush=0, br_cnt=0, mis_cnt=0.
- The clear sweep occupies exactly 2^IDX_W cycles after rst falls. res_ready first rises in cycle 2^IDX_W+1.
- Enqueue-to-upd_en latency: 1 cycle. An entry accepted at edge N is visible at the head after edge N when the FIFO was empty.
- Accept-to-flush latency: 1 cycle; flush pulse width is 1 cycle.
- Back-to-back mispredictions produce flush on consecutive cycles.
- With upd_ready held at 1, sustained throughput is one update per cycle.
- Outputs hold stable while upd_en=1 and upd_ready=0.

## Configuration
- BP_UPDATE_STATS_EN defined:
  - br_cnt increments on every accept.
  - mis_cnt increments on every accept with res_mispredicted=1.
  - Both counters saturate at 16'hFFFF and clear on rst.
- BP_UPDATE_STATS_EN undefined: br_cnt and mis_cnt are constant 0, and no counter registers are synthesized.

## Test plan
- Reset sweep, IDX_W=3: assert rst for 1 cycle -> clr_idx steps 0..7 over 8 cycles with clr_en=1 and busy=1; res_ready rises on cycle 9.
- Single mispredict: in RUN, res_valid=1, res_pc=16'h0008, res_taken=1, res_target=16'h0080, res_mispredicted=1, upd_ready=1 -> next cycle upd_en=1, upd_idx=3'h4, upd_target=16'h0080, flush=1; the cycle after that, upd_en=0 and flush=0.
- Backpressure/full: upd_ready=0, drive 5 consecutive valid resolutions with DEPTH=4 -> 4 accepted, res_ready=0 on the 5th. Raise upd_ready -> 4 writes drain in enqueue order and res_ready returns the cycle after the first dequeue.
- Simultaneous enqueue/dequeue at count=2 with upd_ready=1 -> count stays 2 and the head advances. Wrap-around: verify order is preserved over 10 entries.
- Reset mid-drain: with 3 entries queued and a pending flush, assert rst -> upd_en=0, flush=0, and the sweep restarts at clr_idx=0.
- With BP_UPDATE_STATS_EN defined: 6 accepts, 2 of them mispredicted -> br_cnt=6, mis_cnt=2. Without the macro, both read 0.
